match_timer: RTL and testbench
==============================

# match_timer

Countdown match timer for time-based games. It sits upstream of the game/draw top level: it consumes the configured match length `max_time`, the run enable `time_en` (high while in `play` with time mode selected) and `time_reset`. It produces `time_out`, which the top level uses to move to `end_game`, and it drives the four-digit seven-segment display with the remaining time as M:SS.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: clock cycles per second tick; the bench uses 10.
- `REFRESH_DIV`, 100_000: clock cycles each digit stays selected; the bench uses 4.

Ports:
- `clk`  in  1  system clock (100 MHz board clock).
- `reset`  in  1  reset, asynchronous, active-high.
- `max_time`  in  8  match length in seconds, 0..255.
- `time_en`  in  1  count enable; level-sensitive.
- `time_reset`  in  1  synchronous reload request; level-sensitive.
- `time_out`  out  1  high while the match time is expired.
- `remaining`  out  8  seconds left.
- `seg`  out  7  active-low segments {g,f,e,d,c,b,a}.
- `an`  out  4  active-low digit enables; `an[0]` is the rightmost digit.

## Operation
- FSM states and transitions:
  - IDLE: `remaining` <= `max_time` every cycle; prescaler held at 0. Go to RUN when `time_en`=1.
  - RUN: prescaler counts 0..CLK_HZ-1. At count CLK_HZ-1, prescaler wraps to 0 and `remaining` decrements. If `time_en`=0, go to PAUSE.
  - PAUSE: prescaler and `remaining` hold their values. Return to RUN when `time_en`=1.
  - EXPIRED: `remaining`=0 and `time_out`=1. Holds until `time_reset`; `time_en` is ignored.
- Entry to EXPIRED, from RUN:
  - A tick with `remaining`=1 sets `remaining` to 0 and moves to EXPIRED.
  - RUN with `remaining`=0 (i.e. `max_time`=0) moves to EXPIRED on the next cycle, with no tick.
- `time_reset`=1 has priority over every other condition, from any state:
  - next state IDLE, prescaler 0, `time_out` 0, `remaining` <= `max_time`.
  - A tick in the same cycle is discarded.
- Changes to `max_time` outside IDLE are ignored until the next reload.
- Display digit values:
  - digit 3 is blank (all segments off);
  - digit 2 = `remaining` / 60 (0..4);
  - digit 1 = (`remaining` % 60) / 10;
  - digit 0 = `remaining` % 10.
  - Divide and modulo are by constants, computed combinationally from `remaining`.
- Segment codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111.
- Scan order: a 2-bit digit index advances every REFRESH_DIV cycles, 0→1→2→3→0. `an` is one-hot low on that index.

## Timing
- Reset values: state IDLE, prescaler 0, refresh counter 0, digit index 0, `remaining` 0, `time_out` 0, `seg`=1111111, `an`=1111.
- First clock after reset release: `remaining` = `max_time`.
- `time_out`, `remaining`, `seg` and `an` are all registered; there are no combinational paths from inputs to outputs.
- Counting latency:
  - `time_en` rising in IDLE → first decrement exactly CLK_HZ cycles after the cycle RUN is entered.
  - Next decrements follow every CLK_HZ cycles of RUN time.
  - PAUSE time is not counted; the partial prescaler count is kept.
- `time_out` rises one cycle after the state register reaches EXPIRED. It falls the cycle after `time_reset` is sampled.
- `seg` and `an` lag the digit index by one cycle and change in the same cycle, so there is no ghosting.
- `remaining` never wraps below 0. An asynchronous `reset` mid-count returns to IDLE immediately.

## Test plan
- Reset then release, `max_time`=5, `time_en`=0 → `remaining`=5 after 1 cycle; `time_out`=0; `an` cycles 1110,1101,1011,0111 every 4 cycles; `seg` shows 5, 0, 0, blank.
- CLK_HZ=10, `max_time`=3, `time_en`=1 → `remaining` reads 2, 1, 0 at cycles 10, 20, 30 after RUN entry. `time_out`=1 at cycle 31 and stays high for 100 more cycles with `time_en` still 1.
- `max_time`=3, run 15 cycles, drop `time_en` for 50 cycles, raise it again → the decrement to 1 lands 5 RUN cycles after resume. `remaining` is 2 throughout the pause.
- `max_time`=0, `time_en`=1 → EXPIRED next cycle; `time_out`=1 on the cycle after that; display reads 0:00.
- `time_reset` asserted on the same cycle as a tick, `remaining`=4, `max_time`=9 → `remaining`=9 (no 3); state IDLE; `time_out` 0.
- `max_time`=125 → display shows digits 2, 0, 5 (2:05). Async `reset` mid-RUN → all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/match_timer.sv
// Countdown match timer: reloads from max_time, counts down once per CLK_HZ cycles
// of RUN time, flags expiry, and scans the remaining time as M:SS on a 4-digit display.
module match_timer #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] max_time,
  input  logic       time_en,
  input  logic       time_reset,
  output logic       time_out,
  output logic [7:0] remaining,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST   = PW'(CLK_HZ - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    remaining_q, remaining_d;
  logic          time_out_q, time_out_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    digit_q, digit_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          tick;
  logic [3:0]    dig_min, dig_tens, dig_ones;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    time_out_d  = (state_q == EXPIRED);
    if (time_reset) begin
      // Reload wins over everything, including a tick landing this cycle.
      state_d     = IDLE;
      presc_d     = '0;
      remaining_d = max_time;
      time_out_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          remaining_d = max_time;
          presc_d     = '0;
          if (time_en) state_d = RUN;
        end
        RUN: begin
          if (remaining_q == 8'd0) begin
            state_d = EXPIRED;
          end else if (tick) begin
            presc_d     = '0;
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) state_d = EXPIRED;
            else if (!time_en)       state_d = PAUSE;
          end else begin
            presc_d = presc_q + PW'(1);
            if (!time_en) state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (time_en) state_d = RUN;
        end
        EXPIRED: begin
          remaining_d = 8'd0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dig_min  = 4'(remaining_q / 8'd60);
  assign dig_tens = 4'((remaining_q % 8'd60) / 8'd10);
  assign dig_ones = 4'(remaining_q % 8'd10);

  always_comb begin
    refresh_d = refresh_q + RW'(1);
    digit_d   = digit_q;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d = '0;
      digit_d   = digit_q + 2'd1;
    end
    // seg and an both follow digit_q one cycle later, so they switch together.
    an_d = ~(4'b0001 << digit_q);
    case (digit_q)
      2'd0:    seg_d = seg_code(dig_ones);
      2'd1:    seg_d = seg_code(dig_tens);
      2'd2:    seg_d = seg_code(dig_min);
      default: seg_d = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      remaining_q <= 8'd0;
      time_out_q  <= 1'b0;
      refresh_q   <= '0;
      digit_q     <= 2'd0;
      seg_q       <= 7'b1111111;
      an_q        <= 4'b1111;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      time_out_q  <= time_out_d;
      refresh_q   <= refresh_d;
      digit_q     <= digit_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign time_out  = time_out_q;
  assign remaining = remaining_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule

// File: tb/tb_match_timer.sv
// Bench for match_timer: display vector table, scoreboard of expected countdown
// values with their arrival cycles, and hand sequences for pause/expiry/reload/reset.
module tb_match_timer;
  localparam int CLK_HZ      = 10;
  localparam int REFRESH_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] max_time = 8'd0;
  logic       time_en = 1'b0;
  logic       time_reset = 1'b0;
  logic       time_out;
  logic [7:0] remaining;
  logic [6:0] seg;
  logic [3:0] an;

  match_timer #(.CLK_HZ(CLK_HZ), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk(clk), .reset(reset), .max_time(max_time), .time_en(time_en),
    .time_reset(time_reset), .time_out(time_out), .remaining(remaining),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } sb_t;

  typedef struct {
    logic [7:0] mt;
    logic [3:0] an;
    logic [6:0] seg;
  } dvec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         base;
  sb_t        sb[$];
  logic       mon_en = 1'b0;
  logic [7:0] prev_rem;
  dvec_t      dv[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge. Countdown changes are
  // popped from the scoreboard and checked for both value and arrival cycle.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en && (remaining !== prev_rem)) begin
      if (sb.size() == 0) begin
        chk("rem_unexpected_change", remaining, prev_rem);
      end else begin
        e = sb.pop_front();
        chk("rem_value", remaining, e.val);
        chk("rem_cycle", cyc, e.cyc);
      end
    end
    prev_rem = remaining;
  endtask

  task automatic start_mon();
    prev_rem = remaining;
    mon_en   = 1'b1;
  endtask

  task automatic end_mon();
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    mon_en = 1'b0;
  endtask

  task automatic push(input int c, input logic [7:0] v);
    sb_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic reload(input logic [7:0] mt);
    time_en    = 1'b0;
    max_time   = mt;
    time_reset = 1'b1;
    step();
    time_reset = 1'b0;
    step();
  endtask

  task automatic wait_an(input string name, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (an === exp_an) found = 1'b1;
    end
    chk({name, "_an_seen"}, found, 1);
    chk({name, "_seg"}, seg, exp_seg);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dv[0]  = '{8'd5,   4'b1110, 7'h12};
    dv[1]  = '{8'd5,   4'b1101, 7'h40};
    dv[2]  = '{8'd5,   4'b1011, 7'h40};
    dv[3]  = '{8'd5,   4'b0111, 7'h7F};
    dv[4]  = '{8'd125, 4'b1110, 7'h12};
    dv[5]  = '{8'd125, 4'b1101, 7'h40};
    dv[6]  = '{8'd125, 4'b1011, 7'h24};
    dv[7]  = '{8'd255, 4'b1110, 7'h12};
    dv[8]  = '{8'd255, 4'b1101, 7'h79};
    dv[9]  = '{8'd255, 4'b1011, 7'h19};
    dv[10] = '{8'd59,  4'b1110, 7'h10};
    dv[11] = '{8'd59,  4'b1101, 7'h12};
    dv[12] = '{8'd59,  4'b1011, 7'h40};
    dv[13] = '{8'd60,  4'b1011, 7'h79};
    dv[14] = '{8'd60,  4'b1110, 7'h40};
    dv[15] = '{8'd137, 4'b1110, 7'h78};
    dv[16] = '{8'd137, 4'b1101, 7'h79};
    dv[17] = '{8'd137, 4'b1011, 7'h24};
    dv[18] = '{8'd68,  4'b1110, 7'h00};
    dv[19] = '{8'd246, 4'b1110, 7'h02};
    dv[20] = '{8'd246, 4'b1011, 7'h19};
    dv[21] = '{8'd3,   4'b1110, 7'h30};

    // Reset state, then release with max_time=5
    step();
    chk("rst_remaining", remaining, 0);
    chk("rst_time_out", time_out, 0);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 4'hF);
    max_time = 8'd5;
    reset    = 1'b0;
    step();
    chk("rel_remaining", remaining, 5);
    chk("rel_time_out", time_out, 0);
    chk("rel1_an", an, 4'b1110);
    chk("rel1_seg", seg, 7'h40);
    step();
    chk("rel2_seg", seg, 7'h12);
    repeat (3) step();
    chk("rel5_an", an, 4'b1101);
    chk("rel5_seg", seg, 7'h40);
    repeat (4) step();
    chk("rel9_an", an, 4'b1011);
    repeat (4) step();
    chk("rel13_an", an, 4'b0111);
    chk("rel13_seg", seg, 7'h7F);
    repeat (4) step();
    chk("rel17_an", an, 4'b1110);
    chk("rel17_seg", seg, 7'h12);

    // Display table, all in IDLE
    for (int i = 0; i < 22; i++) begin
      max_time = dv[i].mt;
      step();
      step();
      wait_an($sformatf("disp[%0d]", i), dv[i].an, dv[i].seg);
    end

    // Countdown 3 -> 0, expiry, hold, reload from EXPIRED
    reload(8'd3);
    time_en = 1'b1;
    step();
    chk("run_entry_rem", remaining, 3);
    base = cyc;
    push(base + 10, 8'd2);
    push(base + 20, 8'd1);
    push(base + 30, 8'd0);
    start_mon();
    repeat (30) step();
    chk("to_at_30", time_out, 0);
    step();
    chk("to_at_31", time_out, 1);
    end_mon();
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
        step();
        if (time_out !== 1'b1 || remaining !== 8'd0) bad++;
      end
      chk("expired_hold_bad_cycles", bad, 0);
    end
    time_en    = 1'b0;
    time_reset = 1'b1;
    step();
    chk("reload_time_out", time_out, 0);
    chk("reload_rem", remaining, 3);
    time_reset = 1'b0;

    // Pause keeps the partial prescaler count
    reload(8'd3);
    time_en = 1'b1;
    step();
    base = cyc;
    push(base + 10, 8'd2);
    push(base + 70, 8'd1);
    start_mon();
    repeat (14) step();
    time_en = 1'b0;
    repeat (26) step();
    chk("pause_rem", remaining, 2);
    repeat (24) step();
    time_en = 1'b1;
    repeat (6) step();
    end_mon();
    chk("resume_rem", remaining, 1);

    // max_time = 0 expires without a tick
    reload(8'd0);
    time_en = 1'b1;
    step();
    chk("zero_to_c0", time_out, 0);
    step();
    chk("zero_to_c1", time_out, 0);
    step();
    chk("zero_to_c2", time_out, 1);
    chk("zero_rem", remaining, 0);
    wait_an("zero_d2", 4'b1011, 7'h40);
    wait_an("zero_d0", 4'b1110, 7'h40);
    wait_an("zero_d1", 4'b1101, 7'h40);

    // time_reset coinciding with a tick; max_time change ignored while running
    reload(8'd5);
    time_en = 1'b1;
    step();
    base = cyc;
    push(base + 10, 8'd4);
    start_mon();
    repeat (12) step();
    max_time = 8'd9;
    repeat (3) step();
    end_mon();
    chk("ignore_max_time", remaining, 4);
    repeat (4) step();
    time_reset = 1'b1;
    step();
    chk("tick_reset_rem", remaining, 9);
    chk("tick_reset_to", time_out, 0);
    time_reset = 1'b0;
    time_en    = 1'b0;
    max_time   = 8'd7;
    step();
    chk("tick_reset_idle", remaining, 7);

    // Asynchronous reset mid-run
    reload(8'd125);
    time_en = 1'b1;
    step();
    repeat (25) step();
    chk("prereset_rem", remaining, 123);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rem", remaining, 0);
    chk("async_to", time_out, 0);
    chk("async_seg", seg, 7'h7F);
    chk("async_an", an, 4'hF);
    time_en = 1'b0;
    #2;
    reset = 1'b0;
    step();
    chk("post_reset_rem", remaining, 125);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
